// File: rtl/alu_mc_param.sv
// Multi-cycle integer ALU (add/sub/mul/scaled divide/divide-with-remainder) with valid/ready on both sides.
// Define ALU_SIGNED_EN to add the is_signed port and the signed FIXUP step for divides.
module alu_mc_param #(
  parameter int WIDTH     = 16,
  parameter int DIV_SCALE = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
`ifdef ALU_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic               is_division,
  output logic               div_by_zero,
  output logic               illegal_op
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(RW);
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_DIVR = 3'd4;
  localparam logic [RW-1:0]    SCALE_RW  = RW'(DIV_SCALE);
  localparam logic [WIDTH-1:0] SCALE_W   = WIDTH'(DIV_SCALE);
  localparam logic [CW-1:0]    LAST_STEP = CW'(RW - 1);

`ifdef ALU_SIGNED_EN
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_DIVIDE, S_FIXUP, S_HOLD} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_DIVIDE, S_HOLD} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_op;
  logic [RW-1:0]    r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid, r_is_div, r_dbz, r_ill;
  logic [RW-1:0]    r_result;
  logic [WIDTH-1:0] r_remainder;

  logic w_sgn;
`ifdef ALU_SIGNED_EN
  logic r_signed;
  assign w_sgn = r_signed;
`else
  assign w_sgn = 1'b0;
`endif

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_dbz_rem;
  logic [RW-1:0]    w_a_ext, w_b_ext, w_dividend;

  assign w_a_neg    = w_sgn & r_a[WIDTH-1];
  assign w_b_neg    = w_sgn & r_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -r_a : r_a;
  assign w_b_mag    = w_b_neg ? -r_b : r_b;
  assign w_a_ext    = {{WIDTH{w_a_neg}}, r_a};
  assign w_b_ext    = {{WIDTH{w_b_neg}}, r_b};
  assign w_dividend = (r_op == OP_DIV) ? {{WIDTH{1'b0}}, w_a_mag} * SCALE_RW
                                       : {{WIDTH{1'b0}}, w_a_mag};
  // Low bits of a*scale do not depend on sign extension, so one form serves both modes.
  assign w_dbz_rem  = (r_op == OP_DIV) ? r_a * SCALE_W : r_a;

  // Restoring divider: dividend enters on the first step, quotient bits shift in at the bottom.
  logic [RW-1:0]    w_quo_src, w_quo_next;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;

  assign w_quo_src  = (r_cnt == '0) ? w_dividend : r_quo;
  assign w_shift    = {r_rem, w_quo_src[RW-1]};
  assign w_diff     = w_shift - {1'b0, w_b_mag};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {w_quo_src[RW-2:0], w_ge};

`ifdef ALU_SIGNED_EN
  logic [RW-1:0]    w_fix_quo;
  logic [WIDTH-1:0] w_fix_rem;
  assign w_fix_quo = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
  assign w_fix_rem = w_a_neg ? -r_rem : r_rem;
`endif

  logic [RW-1:0]    w_calc_res;
  logic [WIDTH-1:0] w_calc_rem;
  logic             w_calc_div, w_calc_dbz, w_calc_ill;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
    w_calc_res = '0;
    w_calc_rem = '0;
    w_calc_div = 1'b0;
    w_calc_dbz = 1'b0;
    w_calc_ill = 1'b0;
    case (r_op)
      OP_ADD: w_calc_res = w_a_ext + w_b_ext;
      OP_SUB: w_calc_res = w_a_ext - w_b_ext;
      OP_MUL: w_calc_res = w_a_ext * w_b_ext;
      OP_DIV, OP_DIVR: begin
        w_calc_res = '1;
        w_calc_rem = w_dbz_rem;
        w_calc_div = 1'b1;
        w_calc_dbz = 1'b1;
      end
      default: w_calc_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
      r_is_div    <= 1'b0;
      r_dbz       <= 1'b0;
      r_ill       <= 1'b0;
`ifdef ALU_SIGNED_EN
      r_signed    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a   <= a;
          r_b   <= b;
          r_op  <= op;
          r_rem <= '0;
          r_cnt <= '0;
`ifdef ALU_SIGNED_EN
          r_signed <= is_signed;
`endif
          if ((op == OP_DIV || op == OP_DIVR) && b != '0) r_state <= S_DIVIDE;
          else                                              r_state <= S_CALC;
        end
        S_CALC: begin
          r_result    <= w_calc_res;
          r_remainder <= w_calc_rem;
          r_is_div    <= w_calc_div;
          r_dbz       <= w_calc_dbz;
          r_ill       <= w_calc_ill;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_DIVIDE: begin
          r_quo <= w_quo_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
`ifdef ALU_SIGNED_EN
            if (w_sgn) r_state <= S_FIXUP;
            else
`endif
            begin
              r_result    <= w_quo_next;
              r_remainder <= w_rem_next;
              r_is_div    <= 1'b1;
              r_dbz       <= 1'b0;
              r_ill       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end
        end
`ifdef ALU_SIGNED_EN
        S_FIXUP: begin
          r_result    <= w_fix_quo;
          r_remainder <= w_fix_rem;
          r_is_div    <= 1'b1;
          r_dbz       <= 1'b0;
          r_ill       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
`endif
        S_HOLD: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign remainder   = r_remainder;
  assign is_division = r_is_div;
  assign div_by_zero = r_dbz;
  assign illegal_op  = r_ill;

endmodule
